dbg_mem_responder: RTL and testbench

- Responder end of the bench debug memory-read interface. The bench presents an address and a memory select, and this block returns the 32-bit word from data or instruction memory.
- Sits inside toplevel, between the debug ports and the synchronous-read memory ports.
- Shares those memory ports with the CPU. CPU has priority; a starvation counter forces a one-cycle CPU stall so debug reads always complete while the core runs.

---
 rtl/dbg_pkg.sv | 18 +
 rtl/dbg_mem_responder_if.sv | 26 ++
 rtl/dbg_starve_ctr.sv | 34 +++
 rtl/dbg_mem_responder.sv | 136 +++++++++++++
 tb/tb_dbg_mem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// Shared types and default widths for the debug memory-read responder.
package dbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_INST = 1'b1;

  localparam int D_AW_DFLT = 8;
  localparam int I_AW_DFLT = 10;
  localparam int DW_DFLT   = 32;

endpackage

// File: rtl/dbg_mem_responder_if.sv
// Debug read handshake between the bench (master) and the responder (slave).
interface dbg_mem_responder_if
  import dbg_pkg::*;
#(
  parameter int I_AW = I_AW_DFLT,
  parameter int DW   = DW_DFLT
);

  logic            dbg_req;
  logic            dbg_sel;
  logic [I_AW-1:0] dbg_addr;
  logic            dbg_ack;
  logic [DW-1:0]   dbg_rdata;
  logic            dbg_err;

  modport master (
    output dbg_req, dbg_sel, dbg_addr,
    input  dbg_ack, dbg_rdata, dbg_err
  );

  modport slave (
    input  dbg_req, dbg_sel, dbg_addr,
    output dbg_ack, dbg_rdata, dbg_err
  );

endinterface

// File: rtl/dbg_starve_ctr.sv
// Counts cycles a debug read has been blocked by the CPU; term flags the
// point where the responder must force a CPU stall. STARVE_MAX is 1..255.
module dbg_starve_ctr #(
  parameter int STARVE_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [7:0] cnt_q, cnt_d;

  assign term = (cnt_q == 8'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !term) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dbg_mem_responder.sv
// Serves bench debug reads from data/instruction memory over ports shared
// with the CPU; the CPU wins until the starvation limit forces a stall.
module dbg_mem_responder
  import dbg_pkg::*;
#(
  parameter int D_AW       = D_AW_DFLT,
  parameter int I_AW       = I_AW_DFLT,
  parameter int DW         = DW_DFLT,
  parameter int STARVE_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  dbg_mem_responder_if.slave  dbg,
  input  logic                cpu_d_en,
  input  logic                cpu_i_en,
  output logic                cpu_stall,
  output logic                dmem_en,
  output logic [D_AW-1:0]     dmem_addr,
  input  logic [DW-1:0]       dmem_rdata,
  output logic                imem_en,
  output logic [I_AW-1:0]     imem_addr,
  input  logic [DW-1:0]       imem_rdata
);

  state_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic [I_AW-1:0] addr_q, addr_d;
  logic            ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic busy;
  logic mem_en;
  logic stall;
  logic ctr_clr;
  logic ctr_inc;
  logic ctr_term;

  dbg_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .inc  (ctr_inc),
    .term (ctr_term)
  );

  assign busy = (sel_q == SEL_INST) ? cpu_i_en : cpu_d_en;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    mem_en  = 1'b0;
    stall   = 1'b0;
    ctr_clr = 1'b0;
    ctr_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (dbg.dbg_req) begin
          sel_d  = dbg.dbg_sel;
          addr_d = dbg.dbg_addr;
          err_d  = 1'b0;
          if ((dbg.dbg_sel == SEL_DATA) && (|dbg.dbg_addr[I_AW-1:D_AW])) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!busy) begin
          mem_en  = 1'b1;
          ctr_clr = 1'b1;
          state_d = READ;
        end else if (ctr_term) begin
          // Stall and strobe coincide so the CPU's own access is suppressed.
          stall   = 1'b1;
          mem_en  = 1'b1;
          ctr_clr = 1'b1;
          state_d = READ;
        end else begin
          ctr_inc = 1'b1;
        end
      end
      READ: begin
        rdata_d = (sel_q == SEL_INST) ? imem_rdata : dmem_rdata;
        state_d = RESP;
      end
      RESP: begin
        // First RESP cycle always produces an ack pulse, even if req already fell.
        ack_d = !(ack_q && !dbg.dbg_req);
        if (!dbg.dbg_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cpu_stall = stall;
  assign dmem_en   = mem_en && (sel_q == SEL_DATA);
  assign imem_en   = mem_en && (sel_q == SEL_INST);
  assign dmem_addr = dmem_en ? addr_q[D_AW-1:0] : '0;
  assign imem_addr = imem_en ? addr_q : '0;

  assign dbg.dbg_ack   = ack_q;
  assign dbg.dbg_rdata = rdata_q;
  assign dbg.dbg_err   = err_q;

endmodule

// File: tb/tb_dbg_mem_responder.sv
// Bench for dbg_mem_responder: directed and randomized reads against a
// transaction-level model of latency, data, error and stall behaviour.
module tb_dbg_mem_responder;
  import dbg_pkg::*;

  localparam int D_AW       = 8;
  localparam int I_AW       = 10;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_d_en, cpu_i_en;
  logic            cpu_stall;
  logic            dmem_en, imem_en;
  logic [D_AW-1:0] dmem_addr;
  logic [I_AW-1:0] imem_addr;
  logic [DW-1:0]   dmem_rdata, imem_rdata;

  logic [DW-1:0] dmem [256];
  logic [DW-1:0] imem [1024];

  int nvec  = 0;
  int nfail = 0;

  dbg_mem_responder_if #(.I_AW(I_AW), .DW(DW)) dif ();

  dbg_mem_responder #(
    .D_AW(D_AW), .I_AW(I_AW), .DW(DW), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dbg        (dif),
    .cpu_d_en   (cpu_d_en),
    .cpu_i_en   (cpu_i_en),
    .cpu_stall  (cpu_stall),
    .dmem_en    (dmem_en),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; junk on the bus when not strobed.
  always @(posedge clk) begin
    dmem_rdata <= dmem_en ? dmem[dmem_addr] : $urandom;
    imem_rdata <= imem_en ? imem[imem_addr] : $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(dif.dbg_ack),   32'd0);
    chk({tag, "_rdata"}, dif.dbg_rdata,      32'd0);
    chk({tag, "_err"},   32'(dif.dbg_err),   32'd0);
    chk({tag, "_stall"}, 32'(cpu_stall),     32'd0);
    chk({tag, "_den"},   32'(dmem_en),       32'd0);
    chk({tag, "_daddr"}, 32'(dmem_addr),     32'd0);
    chk({tag, "_ien"},   32'(imem_en),       32'd0);
    chk({tag, "_iaddr"}, 32'(imem_addr),     32'd0);
  endtask

  // One transaction; the selected CPU port is busy for the first busy_k
  // cycles after the request is sampled.
  task automatic do_read(input logic sel, input logic [I_AW-1:0] addr,
                         input int busy_k, input bit early);
    bit          in_range;
    logic [31:0] exp_data;
    int          exp_lat, w, lat;
    int          n_stall, n_coinc, n_den, n_ien, n_bad;
    bit          busy;

    in_range = sel || (addr[I_AW-1:D_AW] == '0);
    exp_data = !in_range ? 32'd0 : (sel ? imem[addr] : dmem[addr[D_AW-1:0]]);
    w        = (busy_k < STARVE_MAX) ? busy_k : STARVE_MAX;
    exp_lat  = in_range ? (w + 3) : 1;
    lat = -1; n_stall = 0; n_coinc = 0; n_den = 0; n_ien = 0; n_bad = 0;

    dif.dbg_req  = 1'b1;
    dif.dbg_sel  = sel;
    dif.dbg_addr = addr;

    for (int e = 0; e < STARVE_MAX + 40 && lat < 0; e++) begin
      @(posedge clk);
      #1;
      busy = (e < busy_k);
      if (sel) begin
        cpu_i_en = busy;
        cpu_d_en = 1'($urandom_range(0, 1));
      end else begin
        cpu_d_en = busy;
        cpu_i_en = 1'($urandom_range(0, 1));
      end
      if (e == 0) begin
        dif.dbg_sel  = 1'($urandom_range(0, 1));
        dif.dbg_addr = I_AW'($urandom);
        if (early) dif.dbg_req = 1'b0;
      end
      @(negedge clk);
      if (cpu_stall) n_stall++;
      if (cpu_stall && (sel ? imem_en : dmem_en)) n_coinc++;
      if (dmem_en) begin
        n_den++;
        if (dmem_addr !== addr[D_AW-1:0]) n_bad++;
      end
      if (imem_en) begin
        n_ien++;
        if (imem_addr !== addr) n_bad++;
      end
      if (dif.dbg_ack) lat = e;
    end

    chk("latency",     32'(lat),     32'(exp_lat));
    chk("rdata",       dif.dbg_rdata, exp_data);
    chk("err",         32'(dif.dbg_err), 32'(!in_range));
    chk("stall_count", 32'(n_stall), 32'((in_range && busy_k > STARVE_MAX) ? 1 : 0));
    chk("stall_en",    32'(n_coinc), 32'((in_range && busy_k > STARVE_MAX) ? 1 : 0));
    chk("dmem_en_cnt", 32'(n_den),   32'((in_range && !sel) ? 1 : 0));
    chk("imem_en_cnt", 32'(n_ien),   32'((in_range && sel) ? 1 : 0));
    chk("mem_addr",    32'(n_bad),   32'd0);

    if (early) begin
      @(negedge clk);
      chk("ack_pulse_end", 32'(dif.dbg_ack), 32'd0);
    end else begin
      @(negedge clk);
      chk("ack_hold", 32'(dif.dbg_ack), 32'd1);
      dif.dbg_req = 1'b0;
      @(negedge clk);
      chk("ack_release", 32'(dif.dbg_ack), 32'd0);
    end
    chk("rdata_hold", dif.dbg_rdata, exp_data);
    cpu_d_en = 1'b0;
    cpu_i_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++)  dmem[i] = $urandom;
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    dmem[8'h05]   = 32'd123;
    dmem[8'h0A]   = 32'hA5A5_0F0F;
    imem[10'h3FF] = 32'hDEAD_BEEF;

    rst = 1'b1;
    cpu_d_en = 1'b0;
    cpu_i_en = 1'b0;
    dif.dbg_req  = 1'b0;
    dif.dbg_sel  = 1'b0;
    dif.dbg_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    do_read(SEL_DATA, 10'h005, 0, 1'b0);     // idle CPU, best-case latency
    do_read(SEL_INST, 10'h3FF, 0, 1'b0);     // top of instruction memory
    do_read(SEL_DATA, 10'h100, 0, 1'b0);     // out of range data address
    do_read(SEL_DATA, 10'h0A, 1000, 1'b0);   // CPU never yields: forced stall
    do_read(SEL_INST, 10'h123, 4, 1'b0);     // short contention
    do_read(SEL_DATA, 10'h005, 0, 1'b1);     // early release
    do_read(SEL_DATA, 10'h0A, 0, 1'b0);      // normal read right after
    do_read(SEL_DATA, 10'h0FF, STARVE_MAX, 1'b0);     // yields exactly at limit
    do_read(SEL_INST, 10'h200, STARVE_MAX + 1, 1'b0); // one past the limit

    // Reset while starving in WAIT.
    dif.dbg_req  = 1'b1;
    dif.dbg_sel  = SEL_DATA;
    dif.dbg_addr = 10'h00A;
    cpu_d_en = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    dif.dbg_req = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1;
    do_read(SEL_DATA, 10'h00A, 1000, 1'b0);

    for (int t = 0; t < 16; t++) begin
      logic            rsel;
      logic [I_AW-1:0] raddr;
      rsel  = 1'($urandom_range(0, 1));
      raddr = I_AW'($urandom);
      if (!rsel && $urandom_range(0, 2) != 0) raddr = raddr & 10'h0FF;
      do_read(rsel, raddr, int'($urandom_range(0, 20)), $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
